path_chunk_dispatch: RTL

PATH_CHUNK_DISPATCH -- requirements
Module: path_chunk_dispatch

---
 rtl/path_chunk_dispatch_if.sv | 50 +++++
 rtl/path_chunk_dispatch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/path_chunk_dispatch_if.sv
// Source-side chunk stream and shared parser-side chunk bus of the path chunk dispatcher.
// Width macros fall back to local defaults when the surrounding build does not define them.
`ifndef DATA_PATH_NBITS
`define DATA_PATH_NBITS 32
`endif
`ifndef CHUNK_LEN_NBITS
`define CHUNK_LEN_NBITS 8
`endif
`ifndef PP_META_RCI_NBITS
`define PP_META_RCI_NBITS 4
`endif
`ifndef PATH_CHUNK_DEPTH_NBITS
`define PATH_CHUNK_DEPTH_NBITS 3
`endif

// Handshake: a source beat transfers on a clk edge where src_valid & src_ready are both high;
// the parser-side bus has no backpressure, each pp_valid cycle is one beat delivered.
interface path_chunk_dispatch_if #(
    parameter int NUM_PP = 4
);
    logic                           src_valid;
    logic [`DATA_PATH_NBITS-1:0]    src_data;
    logic                           src_sop;
    logic                           src_eop;
    logic [`CHUNK_LEN_NBITS-1:0]    src_len;
    logic [`PP_META_RCI_NBITS-1:0]  src_rci;
    logic                           src_ready;
    logic [NUM_PP-1:0]              path_parser_ready;
    logic                           pp_valid;
    logic                           pp_eop;
    logic [`DATA_PATH_NBITS-1:0]    pp_data;
    logic [`CHUNK_LEN_NBITS-1:0]    pp_len;
    logic [1:0]                     pp_id;
    logic                           pp_meta_valid;
    logic [`PP_META_RCI_NBITS-1:0]  pp_meta_rci;
    logic                           err_trunc;
    logic                           err_nosop;

    modport master (
        output src_valid, src_data, src_sop, src_eop, src_len, src_rci, path_parser_ready,
        input  src_ready, pp_valid, pp_eop, pp_data, pp_len, pp_id, pp_meta_valid,
               pp_meta_rci, err_trunc, err_nosop
    );

    modport slave (
        input  src_valid, src_data, src_sop, src_eop, src_len, src_rci, path_parser_ready,
        output src_ready, pp_valid, pp_eop, pp_data, pp_len, pp_id, pp_meta_valid,
               pp_meta_rci, err_trunc, err_nosop
    );
endinterface

// File: rtl/path_chunk_dispatch.sv
// Dispatches path chunks from one source stream to NUM_PP path parsers over a shared bus,
// picking a ready parser round-robin at each chunk start and truncating oversize chunks.
`ifndef DATA_PATH_NBITS
`define DATA_PATH_NBITS 32
`endif
`ifndef CHUNK_LEN_NBITS
`define CHUNK_LEN_NBITS 8
`endif
`ifndef PP_META_RCI_NBITS
`define PP_META_RCI_NBITS 4
`endif
`ifndef PATH_CHUNK_DEPTH_NBITS
`define PATH_CHUNK_DEPTH_NBITS 3
`endif

module path_chunk_dispatch #(
    parameter int NUM_PP    = 4,
    parameter int MAX_BEATS = 2 ** `PATH_CHUNK_DEPTH_NBITS,
    parameter int HOLDOFF   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    path_chunk_dispatch_if.slave  bus,
    output logic [1:0]            dbg_state
);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      last_grant_q;
    logic [HW-1:0]   hold_q [NUM_PP];
    logic [BW-1:0]   beat_q;
    logic [BW-1:0]   beat_d;
    logic [BW-1:0]   beat_inc;
    logic [NUM_PP-1:0] eligible;
    logic            any_eligible;
    logic [1:0]      gnt_idx;
    logic            src_ready_c;
    logic            accept;
    logic            do_grant;
    logic            do_emit;
    logic            emit_eop;
    logic            do_trunc;
    logic            do_nosop;

    assign dbg_state = state_q;

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_PP; k++) begin
            eligible[k] = bus.path_parser_ready[k] && (hold_q[k] == '0);
        end
    end

    assign any_eligible = |eligible;

    // Round-robin search begins one past the most recent grant.
    always_comb begin
        logic found;
        int   idx;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NUM_PP; i++) begin
            idx = (int'(last_grant_q) + i) % NUM_PP;
            if (!found && eligible[idx]) begin
                gnt_idx = 2'(idx);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        src_ready_c = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:       src_ready_c = any_eligible;
                SEND, DROP: src_ready_c = 1'b1;
                default:    src_ready_c = 1'b0;
            endcase
        end
    end

    assign bus.src_ready = src_ready_c;
    assign accept        = bus.src_valid && src_ready_c;
    assign beat_inc      = beat_q + BW'(1);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        do_grant = 1'b0;
        do_emit  = 1'b0;
        emit_eop = 1'b0;
        do_trunc = 1'b0;
        do_nosop = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.src_sop) begin
                        do_grant = 1'b1;
                        do_emit  = 1'b1;
                        beat_d   = BW'(1);
                        if (bus.src_eop) begin
                            emit_eop = 1'b1;
                        end else if (MAX_BEATS == 1) begin
                            emit_eop = 1'b1;
                            do_trunc = 1'b1;
                            state_d  = DROP;
                        end else begin
                            state_d  = SEND;
                        end
                    end else begin
                        do_nosop = 1'b1;
                    end
                end
            end
            SEND: begin
                // src_sop is ignored here: a mid-chunk sop beat is ordinary data.
                if (accept) begin
                    do_emit = 1'b1;
                    beat_d  = beat_inc;
                    if (bus.src_eop) begin
                        emit_eop = 1'b1;
                        state_d  = IDLE;
                    end else if (beat_inc == BW'(MAX_BEATS)) begin
                        emit_eop = 1'b1;
                        do_trunc = 1'b1;
                        state_d  = DROP;
                    end
                end
            end
            DROP: begin
                if (accept && bus.src_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q      <= 2'(NUM_PP - 1);
            beat_q            <= '0;
            bus.pp_valid      <= 1'b0;
            bus.pp_eop        <= 1'b0;
            bus.pp_meta_valid <= 1'b0;
            bus.err_trunc     <= 1'b0;
            bus.err_nosop     <= 1'b0;
            bus.pp_data       <= '0;
            bus.pp_len        <= '0;
            bus.pp_id         <= '0;
            bus.pp_meta_rci   <= '0;
            for (int k = 0; k < NUM_PP; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            // A granted parser was eligible, so its counter is zero when reloaded.
            for (int k = 0; k < NUM_PP; k++) begin
                if (do_grant && (gnt_idx == 2'(k))) begin
                    hold_q[k] <= HW'(HOLDOFF);
                end else if (hold_q[k] != '0) begin
                    hold_q[k] <= hold_q[k] - HW'(1);
                end
            end
            beat_q            <= beat_d;
            bus.pp_valid      <= do_emit;
            bus.pp_eop        <= emit_eop;
            bus.pp_meta_valid <= do_grant;
            bus.err_trunc     <= do_trunc;
            bus.err_nosop     <= do_nosop;
            if (do_emit) begin
                bus.pp_data <= bus.src_data;
            end
            if (do_grant) begin
                bus.pp_id       <= gnt_idx;
                bus.pp_len      <= bus.src_len;
                bus.pp_meta_rci <= bus.src_rci;
                last_grant_q    <= gnt_idx;
            end
        end
    end
endmodule
